// File: rtl/mops_sdo_responder_if.sv
// CAN frame and ADC handshake bundle between a MOPS SDO responder and its
// CAN controller / ADC front end.
interface mops_sdo_responder_if;
  logic        rx_valid;
  logic        rx_ready;
  logic [75:0] rx_frame;
  logic        tx_valid;
  logic        tx_ready;
  logic [75:0] tx_frame;
  logic        adc_req;
  logic [7:0]  adc_ch;
  logic        adc_ack;
  logic [11:0] adc_data;

  modport slave (
    input  rx_valid, rx_frame, tx_ready, adc_ack, adc_data,
    output rx_ready, tx_valid, tx_frame, adc_req, adc_ch
  );

  modport master (
    output rx_valid, rx_frame, tx_ready, adc_ack, adc_data,
    input  rx_ready, tx_valid, tx_frame, adc_req, adc_ch
  );
endinterface

// File: rtl/mops_sdo_responder.sv
// CANopen SDO responder for one MOPS node: expedited ADC uploads, aborts for
// unsupported objects, and NMT boot-up on request. One transaction at a time.
module mops_sdo_responder #(
  parameter logic [15:0] ADC_INDEX    = 16'h2400,
  parameter int unsigned ADC_CHANNELS = 35,
  parameter logic [15:0] ADC_TIMEOUT  = 16'd1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [6:0]                 node_id,
  input  logic                       bootup_req,
  mops_sdo_responder_if.slave        sdo,
  output logic                       busy,
  output logic [15:0]                resp_cnt,
  output logic [7:0]                 err_cnt
);

  typedef enum logic [1:0] {IDLE, DECODE, ADC_WAIT, SEND} state_t;

  state_t      state_q, state_d;
  logic        boot_pend_q, boot_pend_d;
  logic [75:0] rx_q, rx_d;
  logic [75:0] tx_q, tx_d;
  logic [7:0]  ch_q, ch_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] resp_q, resp_d;
  logic [7:0]  err_q, err_d;

  logic [10:0] rx_cob_exp, tx_cob, boot_cob;
  logic [7:0]  b0, b1, b2, b3;

  assign rx_cob_exp = 11'h600 + {4'h0, node_id};
  assign tx_cob     = 11'h580 + {4'h0, node_id};
  assign boot_cob   = 11'h700 + {4'h0, node_id};
  assign b0 = rx_q[63:56];
  assign b1 = rx_q[55:48];
  assign b2 = rx_q[47:40];
  assign b3 = rx_q[39:32];

  function automatic logic [75:0] abort_frame(input logic [10:0] cob,
                                              input logic [23:0] echo,
                                              input logic [31:0] code);
    return {cob, 1'b0, 8'h80, echo,
            code[7:0], code[15:8], code[23:16], code[31:24]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      boot_pend_q <= 1'b0;
      rx_q        <= '0;
      tx_q        <= '0;
      ch_q        <= '0;
      tmo_q       <= '0;
      resp_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      boot_pend_q <= boot_pend_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      ch_q        <= ch_d;
      tmo_q       <= tmo_d;
      resp_q      <= resp_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    boot_pend_d  = boot_pend_q | bootup_req;
    rx_d         = rx_q;
    tx_d         = tx_q;
    ch_d         = ch_q;
    tmo_d        = tmo_q;
    resp_d       = resp_q;
    err_d        = err_q;
    sdo.rx_ready = 1'b0;
    sdo.adc_req  = 1'b0;
    sdo.tx_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (boot_pend_q) begin
          tx_d        = {boot_cob, 1'b0, 64'h0};
          boot_pend_d = bootup_req;
          state_d     = SEND;
        end else begin
          // A boot-up request arriving this cycle wins over a waiting frame.
          sdo.rx_ready = !bootup_req && !rst;
          if (sdo.rx_valid && !bootup_req) begin
            rx_d    = sdo.rx_frame;
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        if (rx_q[75:65] != rx_cob_exp || rx_q[64]) begin
          state_d = IDLE;
        end else if (b0 != 8'h40 || {b2, b1} != ADC_INDEX) begin
          tx_d    = abort_frame(tx_cob, {b1, b2, b3}, 32'h0602_0000);
          state_d = SEND;
        end else if (32'(b3) >= ADC_CHANNELS) begin
          tx_d    = abort_frame(tx_cob, {b1, b2, b3}, 32'h0609_0011);
          state_d = SEND;
        end else begin
          ch_d    = b3;
          tmo_d   = '0;
          state_d = ADC_WAIT;
        end
      end
      ADC_WAIT: begin
        sdo.adc_req = 1'b1;
        if (sdo.adc_ack) begin
          tx_d    = {tx_cob, 1'b0, 8'h43, b1, b2, b3, sdo.adc_data[7:0],
                     4'h0, sdo.adc_data[11:8], 16'h0};
          state_d = SEND;
        end else if (tmo_q == ADC_TIMEOUT - 16'd1) begin
          tx_d    = abort_frame(tx_cob, {b1, b2, b3}, 32'h0800_0000);
          state_d = SEND;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      SEND: begin
        sdo.tx_valid = 1'b1;
        if (sdo.tx_ready) begin
          state_d = IDLE;
          // Frame kind is recovered from the command byte; boot-up (0x00) counts nowhere.
          if (tx_q[63:56] == 8'h43)
            resp_d = resp_q + 16'd1;
          else if (tx_q[63:56] == 8'h80 && err_q != 8'hFF)
            err_d = err_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sdo.tx_frame = tx_q;
  assign sdo.adc_ch   = ch_q;
  assign busy         = (state_q != IDLE);
  assign resp_cnt     = resp_q;
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_mops_sdo_responder.sv
// Directed bench for mops_sdo_responder with hand-computed expected frames.
module tb_mops_sdo_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  node_id;
  logic        bootup_req;
  logic        busy;
  logic [15:0] resp_cnt;
  logic [7:0]  err_cnt;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned n;

  mops_sdo_responder_if bus ();

  mops_sdo_responder #(
    .ADC_INDEX   (16'h2400),
    .ADC_CHANNELS(35),
    .ADC_TIMEOUT (16'd1000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .node_id   (node_id),
    .bootup_req(bootup_req),
    .sdo       (bus.slave),
    .busy      (busy),
    .resp_cnt  (resp_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [75:0] frm(input logic [10:0] cob, input logic rtr,
                                      input logic [63:0] bytes);
    return {cob, rtr, bytes};
  endfunction

  initial begin
    rst = 1'b1;
    node_id = 7'h03;
    bootup_req = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_frame = '0;
    bus.tx_ready = 1'b1;
    bus.adc_ack = 1'b0;
    bus.adc_data = '0;
    step(); step();

    // reset state
    check("rst_tx_valid", 76'(bus.tx_valid), 76'(0));
    check("rst_tx_frame", bus.tx_frame, 76'(0));
    check("rst_adc_req", 76'(bus.adc_req), 76'(0));
    check("rst_adc_ch", 76'(bus.adc_ch), 76'(0));
    check("rst_rx_ready", 76'(bus.rx_ready), 76'(0));
    check("rst_busy", 76'(busy), 76'(0));
    check("rst_resp_cnt", 76'(resp_cnt), 76'(0));
    check("rst_err_cnt", 76'(err_cnt), 76'(0));
    rst = 1'b0;
    step();

    // 1: valid read, ack on first ADC_WAIT cycle
    bus.rx_valid = 1'b1;
    bus.rx_frame = frm(11'h603, 1'b0, 64'h40_00_24_05_00_00_00_00);
    #1 check("t1_rx_ready", 76'(bus.rx_ready), 76'(1));
    step();
    bus.rx_valid = 1'b0;
    check("t1_dec_busy", 76'(busy), 76'(1));
    check("t1_dec_adc_req", 76'(bus.adc_req), 76'(0));
    step();
    check("t1_adc_req", 76'(bus.adc_req), 76'(1));
    check("t1_adc_ch", 76'(bus.adc_ch), 76'(5));
    bus.adc_ack = 1'b1;
    bus.adc_data = 12'hABC;
    step();
    bus.adc_ack = 1'b0;
    check("t1_tx_valid", 76'(bus.tx_valid), 76'(1));
    check("t1_tx_frame", bus.tx_frame, frm(11'h583, 1'b0, 64'h43_00_24_05_BC_0A_00_00));
    step();
    check("t1_tx_fall", 76'(bus.tx_valid), 76'(0));
    check("t1_resp_cnt", 76'(resp_cnt), 76'(1));
    check("t1_busy", 76'(busy), 76'(0));

    // 2: subindex 35 out of range
    bus.rx_valid = 1'b1;
    bus.rx_frame = frm(11'h603, 1'b0, 64'h40_00_24_23_00_00_00_00);
    step();
    bus.rx_valid = 1'b0;
    step();
    check("t2_tx_valid", 76'(bus.tx_valid), 76'(1));
    check("t2_adc_req", 76'(bus.adc_req), 76'(0));
    check("t2_tx_frame", bus.tx_frame, frm(11'h583, 1'b0, 64'h80_00_24_23_11_00_09_06));
    step();
    check("t2_err_cnt", 76'(err_cnt), 76'(1));
    check("t2_resp_cnt", 76'(resp_cnt), 76'(1));

    // 3: wrong COB and RTR frames are dropped
    bus.rx_valid = 1'b1;
    bus.rx_frame = frm(11'h604, 1'b0, 64'h40_00_24_05_00_00_00_00);
    step();
    bus.rx_valid = 1'b0;
    check("t3a_busy", 76'(busy), 76'(1));
    step();
    check("t3a_idle", 76'(busy), 76'(0));
    check("t3a_tx_valid", 76'(bus.tx_valid), 76'(0));
    bus.rx_valid = 1'b1;
    bus.rx_frame = frm(11'h603, 1'b1, 64'h40_00_24_05_00_00_00_00);
    step();
    bus.rx_valid = 1'b0;
    step();
    check("t3b_idle", 76'(busy), 76'(0));
    check("t3b_tx_valid", 76'(bus.tx_valid), 76'(0));
    check("t3_counters", 76'({resp_cnt, err_cnt}), 76'({16'd1, 8'd1}));

    // last valid subindex 34, ack after three wait cycles
    bus.rx_valid = 1'b1;
    bus.rx_frame = frm(11'h603, 1'b0, 64'h40_00_24_22_00_00_00_00);
    step();
    bus.rx_valid = 1'b0;
    step(); step(); step();
    check("t3c_adc_req", 76'(bus.adc_req), 76'(1));
    bus.adc_ack = 1'b1;
    bus.adc_data = 12'h123;
    step();
    bus.adc_ack = 1'b0;
    check("t3c_tx_frame", bus.tx_frame, frm(11'h583, 1'b0, 64'h43_00_24_22_23_01_00_00));
    step();
    check("t3c_resp_cnt", 76'(resp_cnt), 76'(2));

    // wrong object index
    bus.rx_valid = 1'b1;
    bus.rx_frame = frm(11'h603, 1'b0, 64'h40_01_24_00_00_00_00_00);
    step();
    bus.rx_valid = 1'b0;
    step();
    check("t3d_tx_frame", bus.tx_frame, frm(11'h583, 1'b0, 64'h80_01_24_00_00_00_02_06));
    step();
    check("t3d_err_cnt", 76'(err_cnt), 76'(2));

    // 4: ADC timeout
    bus.rx_valid = 1'b1;
    bus.rx_frame = frm(11'h603, 1'b0, 64'h40_00_24_07_00_00_00_00);
    step();
    bus.rx_valid = 1'b0;
    step();
    n = 0;
    while (bus.adc_req && n < 2000) begin
      n++;
      step();
    end
    check("t4_req_cycles", 76'(n), 76'(1000));
    check("t4_tx_valid", 76'(bus.tx_valid), 76'(1));
    check("t4_tx_frame", bus.tx_frame, frm(11'h583, 1'b0, 64'h80_00_24_07_00_00_00_08));
    step();
    check("t4_err_cnt", 76'(err_cnt), 76'(3));

    // 5: boot-up collides with a frame, tx stalled
    bus.tx_ready = 1'b0;
    bootup_req = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_frame = frm(11'h603, 1'b0, 64'h40_00_24_01_00_00_00_00);
    #1 check("t5_rx_ready_req", 76'(bus.rx_ready), 76'(0));
    step();
    bootup_req = 1'b0;
    check("t5_rx_ready_pend", 76'(bus.rx_ready), 76'(0));
    step();
    check("t5_boot_valid", 76'(bus.tx_valid), 76'(1));
    for (int i = 0; i < 10; i++) begin
      check("t5_boot_frame", bus.tx_frame, frm(11'h703, 1'b0, 64'h0));
      check("t5_stall_rx_ready", 76'(bus.rx_ready), 76'(0));
      step();
    end
    bus.tx_ready = 1'b1;
    step();
    check("t5_rx_ready_back", 76'(bus.rx_ready), 76'(1));
    step();
    bus.rx_valid = 1'b0;
    step();
    bus.adc_ack = 1'b1;
    bus.adc_data = 12'h7FF;
    step();
    bus.adc_ack = 1'b0;
    check("t5_sdo_frame", bus.tx_frame, frm(11'h583, 1'b0, 64'h43_00_24_01_FF_07_00_00));
    step();
    check("t5_counters", 76'({resp_cnt, err_cnt}), 76'({16'd3, 8'd3}));

    // 6: reset during ADC_WAIT
    bus.rx_valid = 1'b1;
    bus.rx_frame = frm(11'h603, 1'b0, 64'h40_00_24_02_00_00_00_00);
    step();
    bus.rx_valid = 1'b0;
    step();
    check("t6a_adc_req", 76'(bus.adc_req), 76'(1));
    rst = 1'b1;
    #1;
    check("t6a_adc_req_rst", 76'(bus.adc_req), 76'(0));
    check("t6a_busy_rst", 76'(busy), 76'(0));
    check("t6a_counters_rst", 76'({resp_cnt, err_cnt}), 76'(0));
    rst = 1'b0;
    step();

    // reset during SEND
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_frame = frm(11'h603, 1'b0, 64'h40_00_24_23_00_00_00_00);
    step();
    bus.rx_valid = 1'b0;
    step();
    check("t6b_tx_valid", 76'(bus.tx_valid), 76'(1));
    rst = 1'b1;
    #1;
    check("t6b_tx_valid_rst", 76'(bus.tx_valid), 76'(0));
    check("t6b_tx_frame_rst", bus.tx_frame, 76'(0));
    check("t6b_busy_rst", 76'(busy), 76'(0));
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    step();

    // next request completes normally
    bus.rx_valid = 1'b1;
    bus.rx_frame = frm(11'h603, 1'b0, 64'h40_00_24_00_00_00_00_00);
    step();
    bus.rx_valid = 1'b0;
    step();
    bus.adc_ack = 1'b1;
    bus.adc_data = 12'h001;
    step();
    bus.adc_ack = 1'b0;
    check("t6c_tx_frame", bus.tx_frame, frm(11'h583, 1'b0, 64'h43_00_24_00_01_00_00_00));
    step();
    check("t6c_counters", 76'({resp_cnt, err_cnt}), 76'({16'd1, 8'd0}));

    // err_cnt saturation
    bus.rx_frame = frm(11'h603, 1'b0, 64'h40_00_24_40_00_00_00_00);
    for (int i = 0; i < 260; i++) begin
      bus.rx_valid = 1'b1;
      step();
      bus.rx_valid = 1'b0;
      step(); step();
      if (i == 253) check("t6d_err_254", 76'(err_cnt), 76'(254));
      if (i == 254) check("t6d_err_255", 76'(err_cnt), 76'(255));
    end
    check("t6d_err_sat", 76'(err_cnt), 76'(255));
    check("t6d_resp_cnt", 76'(resp_cnt), 76'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
